memory_subword: RTL and testbench
=================================

Name: memory_subword

Overview:
- Parametrised single-port synchronous memory with word, byte and bit access modes on both read and write.
- Valid/ready request handshake; registered read response; bit writes done as an internal read-modify-write.
- Replaces the fixed 32x64K memory with WrEn/RdEn/RdEn_Opcode. Sits between the lab CPU datapath and bench stimulus as the data store.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8 and at least 16.
- ADDR_W, 16, word address width.
- DEPTH, 2**ADDR_W, number of words; must be at most 2**ADDR_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_wr  in  1  1 = write, 0 = read.
- req_mode  in  2  00 = word, 01 = byte, 10 = bit, 11 = reserved.
- addr  in  ADDR_W  word address.
- byte_sel  in  $clog2(DATA_W/8)  byte lane for byte mode.
- bit_sel  in  $clog2(DATA_W)  bit index for bit mode.
- wdata  in  DATA_W  word mode uses the full bus; byte mode uses [7:0]; bit mode uses [0].
- rd_valid  out  1  one-cycle pulse; rdata/err valid for a read.
- rdata  out  DATA_W  read result, zero-extended in byte and bit modes.
- err  out  1  one-cycle pulse for a reserved mode or addr >= DEPTH.

Behaviour:
- Reset (reset = 0):
  - rd_valid = 0, rdata = 0, err = 0, req_ready = 0 while asserted; req_ready = 1 on the first clk edge after release.
  - FSM goes to IDLE; any pending RMW is dropped.
  - Array contents are not reset and are retained across reset.
- Accept: a request is accepted on a rising edge when req_valid && req_ready. Inputs are sampled only at acceptance.
- Read (any valid mode): rd_valid = 1 on the edge after acceptance (latency 1), with rdata as follows:
  - word: mem[addr].
  - byte: {0, mem[addr][8*byte_sel +: 8]}.
  - bit: {0, mem[addr][bit_sel]}.
  - req_ready stays 1, so back-to-back reads sustain 1 per cycle.
- Word write: written at the accepting edge with all byte enables set; req_ready stays 1.
- Byte write: written at the accepting edge with a single byte enable; wdata[7:0] is replicated across lanes. req_ready stays 1.
- Bit write (RMW):
  - FSM IDLE -> RMW on acceptance; the array read of addr is issued at that edge.
  - In RMW, req_ready = 0. The read word is merged with wdata[0] at bit_sel and written at the next edge, then FSM -> IDLE.
  - Occupancy is 2 cycles; the earliest next acceptance is the edge after the write.
- Read-after-write to the same address, including immediately after an RMW, returns the new data; no forwarding is needed because the array updates before the next read edge.
- Error (mode 11 or addr >= DEPTH):
  - Request is accepted and the array is not modified.
  - err pulses 1 cycle after acceptance. For reads, rd_valid pulses with it and rdata = 0.
- Writes produce no rd_valid.
- Reset asserted during RMW: the write is not performed and the word keeps its old value.
- req_valid while req_ready = 0 is ignored. The requester must hold the request until it is accepted.

Decomposition:
- Shared package memory_pkg: typedef enum logic [1:0] mem_mode_e {MODE_WORD, MODE_BYTE, MODE_BIT, MODE_RSVD}; typedef enum logic fsm_e {ST_IDLE, ST_RMW}.
- Sub-module mem_array: synchronous single-port RAM with parameters DATA_W and DEPTH, a byte-enable write and a registered read.
- The top level holds the FSM, lane extract/merge logic, response registers and error checks.

Test Plan:
- Word write mem[i] = i for i = 0..65535, then word read each -> rd_valid 1 cycle after acceptance, rdata == i, 0 mismatches, err never asserted.
- Write 0x000000F4 to addr 5. Byte read lane 0 -> 0x000000F4; bit read bit_sel 7 -> 1; bit read bit_sel 3 -> 0.
- Bit write:
  - Word write 0xFFFF0000 to addr 9, then bit write bit_sel 3 = 1 -> req_ready 0 for exactly 1 cycle.
  - Word read addr 9 -> 0xFFFF0008.
  - Byte write lane 2 = 0xAB -> word read 0xFFAB0008.
- Reserved mode read and write to addr 9 -> err pulse 1 cycle. Read gives rdata 0 with rd_valid 1; mem[9] unchanged at 0xFFAB0008.
- Reset during RMW: word write 0 to addr 4, start bit write bit_sel 0 = 1, assert reset in the RMW cycle.
  - Outputs go 0 immediately and req_ready returns 1 after release.
  - Word read addr 4 -> 0x00000000.
- Parameter sweep: DATA_W = 64, ADDR_W = 8, DEPTH = 200.
  - Byte lane 7 and bit 63 read and write correctly.
  - Access to addr 200 -> err pulse, array unchanged.

Source files
------------

// File: rtl/memory_pkg.sv
// memory_pkg: access modes and control states shared by the sub-word memory.
package memory_pkg;
  typedef enum logic [1:0] {MODE_WORD, MODE_BYTE, MODE_BIT, MODE_RSVD} mem_mode_e;
  typedef enum logic {ST_IDLE, ST_RMW} fsm_e;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM with per-byte write enables and a registered read.
module mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 256,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int NB = DATA_W / 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic [NB-1:0]     be,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // read-first: rdata returns the word as it was before this edge's write
  always_ff @(posedge clk)
    if (en) begin
      rdata <= mem[addr];
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: rtl/memory_subword.sv
// memory_subword: word/byte/bit access memory with valid/ready requests.
// Bit writes take two cycles: array read at acceptance, merged write-back in RMW.
module memory_subword
  import memory_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 2 ** ADDR_W,
  localparam int BSW = $clog2(DATA_W / 8),
  localparam int BIW = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BSW-1:0]    byte_sel,
  input  logic [BIW-1:0]    bit_sel,
  input  logic [DATA_W-1:0] wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int NB = DATA_W / 8;
  fsm_e state, nextState;
  mem_mode_e modeQ;
  logic initDone, accept, bad, rspValid, errQ, rmwVal, arrEn;
  logic [NB-1:0] arrBe;
  logic [AW-1:0] arrAddr, rmwAddr;
  logic [DATA_W-1:0] arrWdata, arrRdata, merged;
  logic [BSW-1:0] byteSelQ;
  logic [BIW-1:0] bitSelQ;

  assign req_ready = initDone && state == ST_IDLE;
  assign accept = req_valid && req_ready;
  assign bad = req_mode == MODE_RSVD || {1'b0, addr} >= (ADDR_W + 1)'(DEPTH);
  assign rd_valid = rspValid;
  assign err = errQ;

  // a bit write only reads at acceptance; the merged word goes back in RMW
  always_comb begin
    nextState = state == ST_IDLE && accept && !bad && req_wr && req_mode == MODE_BIT ? ST_RMW : ST_IDLE;
    merged = arrRdata;
    merged[bitSelQ] = rmwVal;
    arrEn = state == ST_RMW || (accept && !bad);
    arrAddr = state == ST_RMW ? rmwAddr : addr[AW-1:0];
    arrBe = state == ST_RMW || (req_wr && req_mode == MODE_WORD) ? '1 :
            req_wr && req_mode == MODE_BYTE ? NB'(1) << byte_sel : '0;
    arrWdata = state == ST_RMW ? merged : req_mode == MODE_BYTE ? {NB{wdata[7:0]}} : wdata;
    rdata = !rspValid || errQ ? '0 :
            modeQ == MODE_BYTE ? DATA_W'(arrRdata[8*byteSelQ +: 8]) :
            modeQ == MODE_BIT ? DATA_W'(arrRdata[bitSelQ]) : arrRdata;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      initDone <= 1'b0;
      rspValid <= 1'b0;
      errQ <= 1'b0;
      modeQ <= MODE_WORD;
      byteSelQ <= '0;
      bitSelQ <= '0;
      rmwAddr <= '0;
      rmwVal <= 1'b0;
    end else begin
      state <= nextState;
      initDone <= 1'b1;
      rspValid <= accept && !req_wr;
      errQ <= accept && bad;
      if (accept) begin
        modeQ <= mem_mode_e'(req_mode);
        byteSelQ <= byte_sel;
        bitSelQ <= bit_sel;
        rmwAddr <= addr[AW-1:0];
        rmwVal <= wdata[0];
      end
    end

  mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) uArray (
    .clk(clk),
    .en(arrEn),
    .be(arrBe),
    .addr(arrAddr),
    .wdata(arrWdata),
    .rdata(arrRdata)
  );
endmodule

// File: tb/tb_memory_subword.sv
// tb_memory_subword: directed checks of a default 32-bit instance and a 64-bit/200-word instance.
module tb_memory_subword;
  import memory_pkg::*;
  logic clk = 0, reset = 0, reqValid = 0, reqWr = 0, tgt = 0;
  logic [1:0] reqMode = 0;
  logic [15:0] addr = 0;
  logic [2:0] byteSel = 0;
  logic [5:0] bitSel = 0;
  logic [63:0] wdata = 0;
  logic readyA, readyB, rdValidA, rdValidB, errA, errB;
  logic [31:0] rdataA;
  logic [63:0] rdataB;
  logic ready, rdValid, err;
  logic [63:0] rdata;
  int nChk = 0, nErr = 0;

  always #5 clk = ~clk;

  memory_subword dutA (
    .clk(clk), .reset(reset), .req_valid(reqValid && !tgt), .req_ready(readyA),
    .req_wr(reqWr), .req_mode(reqMode), .addr(addr), .byte_sel(byteSel[1:0]),
    .bit_sel(bitSel[4:0]), .wdata(wdata[31:0]), .rd_valid(rdValidA), .rdata(rdataA), .err(errA)
  );

  memory_subword #(.DATA_W(64), .ADDR_W(8), .DEPTH(200)) dutB (
    .clk(clk), .reset(reset), .req_valid(reqValid && tgt), .req_ready(readyB),
    .req_wr(reqWr), .req_mode(reqMode), .addr(addr[7:0]), .byte_sel(byteSel),
    .bit_sel(bitSel), .wdata(wdata), .rd_valid(rdValidB), .rdata(rdataB), .err(errB)
  );

  assign ready = tgt ? readyB : readyA;
  assign rdValid = tgt ? rdValidB : rdValidA;
  assign err = tgt ? errB : errA;
  assign rdata = tgt ? rdataB : {32'b0, rdataA};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChk++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // holds the request until accepted; returns #1 after the accepting edge
  task automatic req(input bit w, input logic [1:0] m, input logic [15:0] a, input logic [63:0] d, input int sel);
    int n = 0;
    reqWr = w; reqMode = m; addr = a; wdata = d;
    byteSel = sel[2:0]; bitSel = sel[5:0];
    reqValid = 1;
    while (!ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    reqValid = 0;
  endtask

  task automatic rd(input logic [1:0] m, input logic [15:0] a, input int sel, input logic [63:0] exp, input string tag);
    req(0, m, a, 0, sel);
    chk({tag, "_vld"}, rdValid, 1);
    chk({tag, "_err"}, err, 0);
    chk(tag, rdata, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {readyA, readyB}, 0);
    chk("rst_rdvalid", {rdValidA, rdValidB}, 0);
    chk("rst_err", {errA, errB}, 0);
    chk("rst_rdata", rdataA | rdataB[31:0] | rdataB[63:32], 0);
    reset = 1;
    chk("rel_ready_pre", readyA, 0);
    @(posedge clk); #1;
    chk("rel_ready", {readyA, readyB}, 2'b11);

    // sweep the bottom and top 1K words of the default instance
    for (int i = 0; i < 1024; i++) begin
      req(1, MODE_WORD, 16'(i), 64'(i), 0);
      req(1, MODE_WORD, 16'(65535 - i), 64'(65535 - i), 0);
    end
    chk("wr_no_rdvalid", rdValid, 0);
    for (int i = 0; i < 1024; i++) begin
      rd(MODE_WORD, 16'(i), 0, 64'(i), "sweep_lo");
      rd(MODE_WORD, 16'(65535 - i), 0, 64'(65535 - i), "sweep_hi");
    end
    @(posedge clk); #1;
    chk("rdvalid_pulse", rdValid, 0);

    req(1, MODE_WORD, 5, 64'h0000_00F4, 0);
    rd(MODE_BYTE, 5, 0, 64'hF4, "byte_lane0");
    rd(MODE_BIT, 5, 7, 1, "bit7");
    rd(MODE_BIT, 5, 3, 0, "bit3");
    rd(MODE_BYTE, 5, 1, 0, "byte_lane1");

    req(1, MODE_WORD, 9, 64'hFFFF_0000, 0);
    req(1, MODE_BIT, 9, 1, 3);
    chk("rmw_busy", ready, 0);
    chk("rmw_no_rdvalid", rdValid, 0);
    @(posedge clk); #1;
    chk("rmw_done", ready, 1);
    rd(MODE_WORD, 9, 0, 64'hFFFF_0008, "rmw_word");
    req(1, MODE_BYTE, 9, 64'hAB, 2);
    rd(MODE_WORD, 9, 0, 64'hFFAB_0008, "byte_wr");
    req(1, MODE_BIT, 9, 0, 31);
    rd(MODE_WORD, 9, 0, 64'h7FAB_0008, "raw_after_rmw");
    req(1, MODE_BIT, 9, 1, 31);

    req(0, MODE_RSVD, 9, 0, 0);
    chk("rsvd_rd_err", err, 1);
    chk("rsvd_rd_vld", rdValid, 1);
    chk("rsvd_rd_data", rdata, 0);
    @(posedge clk); #1;
    chk("rsvd_err_pulse", err, 0);
    req(1, MODE_RSVD, 9, 64'h1234_5678, 0);
    chk("rsvd_wr_err", err, 1);
    chk("rsvd_wr_vld", rdValid, 0);
    rd(MODE_WORD, 9, 0, 64'hFFAB_0008, "rsvd_unchanged");

    req(1, MODE_WORD, 4, 0, 0);
    req(1, MODE_BIT, 4, 1, 0);
    chk("rmw_busy4", ready, 0);
    reset = 0;
    #1;
    chk("rstrmw_ready", ready, 0);
    chk("rstrmw_vld", rdValid, 0);
    chk("rstrmw_err", err, 0);
    @(posedge clk); #1;
    reset = 1;
    chk("rstrmw_ready_held", ready, 0);
    @(posedge clk); #1;
    chk("rstrmw_ready_back", ready, 1);
    rd(MODE_WORD, 4, 0, 0, "rstrmw_word");

    tgt = 1;
    req(1, MODE_WORD, 3, 64'h0123_4567_89AB_CDEF, 0);
    req(1, MODE_BYTE, 3, 64'hA5, 7);
    rd(MODE_WORD, 3, 0, 64'hA523_4567_89AB_CDEF, "w64_byte7_wr");
    rd(MODE_BYTE, 3, 7, 64'hA5, "w64_byte7_rd");
    rd(MODE_BIT, 3, 63, 1, "w64_bit63_rd");
    req(1, MODE_BIT, 3, 0, 63);
    chk("w64_rmw_busy", ready, 0);
    rd(MODE_WORD, 3, 0, 64'h2523_4567_89AB_CDEF, "w64_bit63_wr");
    req(1, MODE_WORD, 199, 64'hDEAD_BEEF_0000_0001, 0);
    req(0, MODE_WORD, 200, 0, 0);
    chk("w64_oob_rd_err", err, 1);
    chk("w64_oob_rd_data", rdata, 0);
    req(1, MODE_WORD, 200, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    chk("w64_oob_wr_err", err, 1);
    @(posedge clk); #1;
    chk("w64_oob_err_pulse", err, 0);
    rd(MODE_WORD, 199, 0, 64'hDEAD_BEEF_0000_0001, "w64_last");
    rd(MODE_WORD, 3, 0, 64'h2523_4567_89AB_CDEF, "w64_unchanged");

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end
endmodule
